// File: rtl/pdp8_panel_pkg.sv
// ---------------------------------------------------------------------------
// pdp8_panel_pkg
// Shared definitions for the PDP-8 front-panel run-control sequencer:
// the 3-bit FSM state encoding (also exported on the debug state port)
// and the default debounce/clear timing parameters.
// ---------------------------------------------------------------------------
package pdp8_panel_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_CLEARING = 3'd1,
    ST_RUNNING  = 3'd2,
    ST_STEPPING = 3'd3,
    ST_HALTING  = 3'd4
  } state_e;

  localparam int DEF_DEBOUNCE_TICKS = 16;
  localparam int DEF_CLEAR_CYCLES   = 4;
  localparam int DEF_CNT_W          = 8;

endpackage

// File: rtl/pdp8_panel_sequencer_if.sv
// ---------------------------------------------------------------------------
// pdp8_panel_sequencer_if
// Groups the panel-side inputs (debounce strobe, raw buttons, step switch)
// and the core-side status/control signals of the run-control sequencer.
//   master : board/core side - drives TICK, buttons, SW_STEP, cpu status;
//            observes the core controls, LEDs and debug state.
//   slave  : the sequencer itself.
// ---------------------------------------------------------------------------
interface pdp8_panel_sequencer_if;
  import pdp8_panel_pkg::*;

  logic               TICK;
  logic               nBUT_RUN;
  logic               nBUT_CLEAR;
  logic               SW_STEP;
  logic               cpu_halted;
  logic               cpu_instr_done;
  logic               cpu_reset;
  logic               cpu_clear;
  logic               cpu_run;
  logic               cpu_halt_req;
  logic               led_run;
  logic               led_busy;
  logic [STATE_W-1:0] state;

  modport master (
    output TICK, nBUT_RUN, nBUT_CLEAR, SW_STEP, cpu_halted, cpu_instr_done,
    input  cpu_reset, cpu_clear, cpu_run, cpu_halt_req, led_run, led_busy, state
  );

  modport slave (
    input  TICK, nBUT_RUN, nBUT_CLEAR, SW_STEP, cpu_halted, cpu_instr_done,
    output cpu_reset, cpu_clear, cpu_run, cpu_halt_req, led_run, led_busy, state
  );

endinterface

// File: rtl/pdp8_debounce.sv
// ---------------------------------------------------------------------------
// pdp8_debounce
// One active-low push button: 2-flop synchronizer, TICK-qualified debounce
// counter and a one-cycle press pulse on the debounced 1->0 transition.
//   CLK, RESET : clock, asynchronous active-high reset
//   tick_i     : debounce strobe (one CLK cycle wide)
//   n_but_i    : raw asynchronous button, active low
//   press_o    : one-cycle pulse, two cycles after the accepting TICK
// ---------------------------------------------------------------------------
module pdp8_debounce #(
  parameter int DEBOUNCE_TICKS = pdp8_panel_pkg::DEF_DEBOUNCE_TICKS,
  parameter int CNT_W          = pdp8_panel_pkg::DEF_CNT_W
) (
  input  logic CLK,
  input  logic RESET,
  input  logic tick_i,
  input  logic n_but_i,
  output logic press_o
);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only survives while the synced level disagrees with the
  // accepted level; any agreement (even a single bounce) restarts it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (!tick_i) begin
        cnt_d = cnt_q;
      end else if (cnt_q == CNT_W'(DEBOUNCE_TICKS - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      stable_q     <= 1'b1;
      stable_dly_q <= 1'b1;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= n_but_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      cnt_q        <= cnt_d;
      stable_dly_q <= stable_q;
      // Registered edge detect: pulse in the cycle after stable fell.
      press_q      <= stable_dly_q & ~stable_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pdp8_panel_sequencer.sv
// ---------------------------------------------------------------------------
// pdp8_panel_sequencer
// Front-panel run-control for the PDP-8 core. Debounces RUN/STOP and CLEAR,
// then sequences the core through clear, run, single-step and halt.
//   CLK, RESET : CPU clock, asynchronous active-high reset
//   bus (slave): TICK, nBUT_RUN, nBUT_CLEAR, SW_STEP, cpu_halted,
//                cpu_instr_done in; cpu_reset, cpu_clear, cpu_run,
//                cpu_halt_req, led_run, led_busy, state out
// ---------------------------------------------------------------------------
module pdp8_panel_sequencer
  import pdp8_panel_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int CLEAR_CYCLES   = DEF_CLEAR_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input logic                   CLK,
  input logic                   RESET,
  pdp8_panel_sequencer_if.slave bus
);

  logic             run_press, clr_press;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             cpu_reset_q, cpu_clear_q, cpu_run_q, cpu_halt_req_q;
  logic             led_run_q, led_busy_q;

  pdp8_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_db_run (
    .CLK     (CLK),
    .RESET   (RESET),
    .tick_i  (bus.TICK),
    .n_but_i (bus.nBUT_RUN),
    .press_o (run_press)
  );

  pdp8_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .CNT_W(CNT_W)) u_db_clear (
    .CLK     (CLK),
    .RESET   (RESET),
    .tick_i  (bus.TICK),
    .n_but_i (bus.nBUT_CLEAR),
    .press_o (clr_press)
  );

  // Clear press overrides everything, including a simultaneous run press.
  // Halt from the core outranks a run press while RUNNING.
  always_comb begin
    state_d   = ST_IDLE;
    clr_cnt_d = '0;
    if (clr_press) begin
      state_d = ST_CLEARING;
    end else begin
      case (state_q)
        ST_IDLE:     state_d = !run_press ? ST_IDLE :
                               (bus.SW_STEP ? ST_STEPPING : ST_RUNNING);
        ST_CLEARING: begin
          if (clr_cnt_q != CNT_W'(CLEAR_CYCLES - 1)) begin
            state_d   = ST_CLEARING;
            clr_cnt_d = clr_cnt_q + CNT_W'(1);
          end
        end
        ST_RUNNING:  state_d = bus.cpu_halted ? ST_IDLE :
                               (run_press ? ST_HALTING : ST_RUNNING);
        ST_STEPPING: state_d = bus.cpu_instr_done ? ST_IDLE : ST_STEPPING;
        ST_HALTING:  state_d = bus.cpu_halted ? ST_IDLE : ST_HALTING;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch with the state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      clr_cnt_q      <= '0;
      cpu_reset_q    <= 1'b0;
      cpu_clear_q    <= 1'b0;
      cpu_run_q      <= 1'b0;
      cpu_halt_req_q <= 1'b0;
      led_run_q      <= 1'b0;
      led_busy_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      cpu_reset_q    <= (state_d == ST_CLEARING);
      cpu_clear_q    <= (state_d == ST_CLEARING);
      cpu_run_q      <= (state_d == ST_RUNNING) || (state_d == ST_STEPPING) ||
                        (state_d == ST_HALTING);
      cpu_halt_req_q <= (state_d == ST_HALTING);
      led_run_q      <= (state_d == ST_RUNNING) || (state_d == ST_STEPPING) ||
                        (state_d == ST_HALTING);
      led_busy_q     <= (state_d == ST_CLEARING);
    end
  end

  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.cpu_clear    = cpu_clear_q;
  assign bus.cpu_run      = cpu_run_q;
  assign bus.cpu_halt_req = cpu_halt_req_q;
  assign bus.led_run      = led_run_q;
  assign bus.led_busy     = led_busy_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_pdp8_panel_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pdp8_panel_sequencer
// Self-checking bench: a behavioural model of the panel rules runs beside
// the DUT and is compared on every clock; directed scenarios add literal
// expectations, followed by a randomized button/core-status phase.
// ---------------------------------------------------------------------------
module tb_pdp8_panel_sequencer;

  localparam int DB       = 4;
  localparam int CC       = 4;
  localparam int TICK_DIV = 8;
  localparam int HOLD     = (DB + 2) * TICK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;

  pdp8_panel_sequencer_if pif ();

  pdp8_panel_sequencer #(
    .DEBOUNCE_TICKS (DB),
    .CLEAR_CYCLES   (CC),
    .CNT_W          (8)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (pif)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- behavioural model ----------------
  int edge_no       = 0;
  int run_flip_edge = -1;
  int m_state       = 0;
  int m_clr_elapsed = 0;
  int m_s1     [2]  = '{1, 1};
  int m_s2     [2]  = '{1, 1};
  int m_stable [2]  = '{1, 1};
  int m_dcnt   [2]  = '{0, 0};
  int m_pend   [2]  = '{-1, -1};
  int m_npress [2]  = '{0, 0};

  task automatic model_reset();
    m_state       = 0;
    m_clr_elapsed = 0;
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 1; m_s2[b] = 1; m_stable[b] = 1; m_dcnt[b] = 0; m_pend[b] = -1;
    end
  endtask

  // One clock edge of the panel rules. Index 0 = RUN button, 1 = CLEAR.
  task automatic model_step();
    bit pr [2];
    int raw [2];
    int lvl;
    edge_no++;
    if (rst) begin
      model_reset();
      return;
    end
    raw[0] = int'(pif.nBUT_RUN);
    raw[1] = int'(pif.nBUT_CLEAR);
    for (int b = 0; b < 2; b++) begin
      pr[b] = (m_pend[b] == edge_no);
      lvl = m_s2[b]; m_s2[b] = m_s1[b]; m_s1[b] = raw[b];
      if (lvl == m_stable[b]) m_dcnt[b] = 0;
      else if (pif.TICK) begin
        m_dcnt[b]++;
        if (m_dcnt[b] == DB) begin
          m_dcnt[b]   = 0;
          m_stable[b] = lvl;
          if (lvl == 0) begin
            m_pend[b] = edge_no + 2;
            m_npress[b]++;
            if (b == 0) run_flip_edge = edge_no;
          end
        end
      end
    end
    if (pr[1]) begin
      m_state       = 1;
      m_clr_elapsed = 1;
    end else begin
      case (m_state)
        0: if (pr[0]) m_state = pif.SW_STEP ? 3 : 2;
        1: if (m_clr_elapsed == CC) m_state = 0; else m_clr_elapsed++;
        2: if (pif.cpu_halted) m_state = 0; else if (pr[0]) m_state = 4;
        3: if (pif.cpu_instr_done) m_state = 0;
        4: if (pif.cpu_halted) m_state = 0;
        default: m_state = 0;
      endcase
    end
  endtask

  // {cpu_reset, cpu_clear, cpu_run, cpu_halt_req, led_run, led_busy, state}
  function automatic logic [8:0] exp_vec(input int s);
    case (s)
      1:       return {6'b110001, 3'd1};
      2:       return {6'b001010, 3'd2};
      3:       return {6'b001010, 3'd3};
      4:       return {6'b001110, 3'd4};
      default: return 9'd0;
    endcase
  endfunction

  function automatic logic [8:0] dut_vec();
    return {pif.cpu_reset, pif.cpu_clear, pif.cpu_run, pif.cpu_halt_req,
            pif.led_run, pif.led_busy, pif.state};
  endfunction

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      n_cmp++;
      if (dut_vec() !== exp_vec(m_state)) begin
        n_fail++;
        $display("FAIL cycle_outputs edge %0d: got %b required %b",
                 edge_no, dut_vec(), exp_vec(m_state));
      end
    end
  end

  // Debounce strobe every TICK_DIV clocks.
  initial begin
    int tcnt = 0;
    pif.TICK = 1'b0;
    forever begin
      @(negedge clk);
      tcnt++;
      pif.TICK = (tcnt % TICK_DIV == 0);
    end
  end

  // cpu_run window monitor.
  int  run_windows = 0;
  bit  run_seen    = 0;
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (pif.cpu_run && !prev) run_windows++;
      if (pif.cpu_run) run_seen = 1;
      prev = pif.cpu_run;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_btn(input int which, input logic v);
    if (which == 0) pif.nBUT_RUN = v;
    else            pif.nBUT_CLEAR = v;
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b0);
    cyc(HOLD);
    set_btn(which, 1'b1);
    cyc(HOLD);
  endtask

  task automatic wait_state(input int s, input int budget, input string nm);
    int n = 0;
    while (int'(pif.state) != s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nm, int'(pif.state), s);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int np0, delta, clr_cycles, run_bad, hold_rst;
    pif.nBUT_RUN       = 1'b1;
    pif.nBUT_CLEAR     = 1'b1;
    pif.SW_STEP        = 1'b0;
    pif.cpu_halted     = 1'b0;
    pif.cpu_instr_done = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_outputs", int'(dut_vec()), 0);
    cyc(3);
    rst = 1'b0;
    cyc(4);

    // Debounce: bounce 0/1/0, then hold low; one press, state 2 two edges
    // after the accepting tick.
    np0 = m_npress[0];
    pif.nBUT_RUN = 1'b0; cyc(10);
    pif.nBUT_RUN = 1'b1; cyc(6);
    pif.nBUT_RUN = 1'b0;
    begin
      int n = 0;
      while (pif.state != 3'd2 && n < 100) begin @(negedge clk); n++; end
    end
    delta = edge_no - run_flip_edge;
    check("run_state_after_bounce", int'(pif.state), 2);
    check("press_latency_edges", delta, 2);
    check("cpu_run_after_press", int'(pif.cpu_run), 1);
    cyc(HOLD);
    pif.nBUT_RUN = 1'b1;
    cyc(HOLD);
    check("single_press_count", m_npress[0] - np0, 1);
    check("release_no_event", int'(pif.state), 2);

    // Run/stop: second press requests halt; core halt returns to IDLE.
    press(0);
    check("halting_state", int'(pif.state), 4);
    check("halt_req_high", int'(pif.cpu_halt_req), 1);
    check("run_held_in_halting", int'(pif.cpu_run), 1);
    pif.cpu_halted = 1'b1;
    @(negedge clk);
    check("halt_to_idle_state", int'(pif.state), 0);
    check("halt_drops_run", int'({pif.cpu_run, pif.cpu_halt_req}), 0);
    pif.cpu_halted = 1'b0;

    // Clear from RUNNING.
    press(0);
    check("running_before_clear", int'(pif.state), 2);
    pif.nBUT_CLEAR = 1'b0;
    clr_cycles = 0;
    run_bad    = 0;
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      if (pif.cpu_clear && pif.cpu_reset) clr_cycles++;
      if (pif.cpu_clear && pif.cpu_run) run_bad++;
      if (clr_cycles > 0 && !pif.cpu_clear) break;
    end
    check("clear_cycles", clr_cycles, CC);
    check("run_during_clear", run_bad, 0);
    check("after_clear_outputs", int'(dut_vec()), 0);
    cyc(HOLD);
    pif.nBUT_CLEAR = 1'b1;
    cyc(HOLD);

    // Single step three times.
    pif.SW_STEP = 1'b1;
    run_windows = 0;
    for (int i = 0; i < 3; i++) begin
      pif.nBUT_RUN = 1'b0;
      wait_state(3, 100, "stepping_state");
      check("step_run_high", int'(pif.cpu_run), 1);
      cyc(10);
      pif.cpu_instr_done = 1'b1;
      @(negedge clk);
      pif.cpu_instr_done = 1'b0;
      check("step_run_falls", int'(pif.cpu_run), 0);
      cyc(HOLD);
      pif.nBUT_RUN = 1'b1;
      cyc(HOLD);
    end
    check("step_windows", run_windows, 3);
    pif.SW_STEP = 1'b0;

    // Priority: simultaneous clear and run presses.
    run_seen = 0;
    pif.nBUT_RUN   = 1'b0;
    pif.nBUT_CLEAR = 1'b0;
    wait_state(1, 100, "both_press_clearing");
    cyc(HOLD);
    pif.nBUT_RUN   = 1'b1;
    pif.nBUT_CLEAR = 1'b1;
    cyc(HOLD);
    check("both_press_no_run", int'(run_seen), 0);
    check("both_press_idle", int'(pif.state), 0);

    // Async reset mid-CLEARING.
    pif.nBUT_CLEAR = 1'b0;
    wait_state(1, 100, "clearing_before_reset");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_mid_clearing", int'(dut_vec()), 0);
    pif.nBUT_CLEAR = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(HOLD);
    check("idle_after_reset_clear", int'(pif.state), 0);

    // Async reset mid-HALTING.
    press(0);
    press(0);
    check("halting_before_reset", int'(pif.state), 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_mid_halting", int'(dut_vec()), 0);
    cyc(2);
    rst = 1'b0;
    cyc(HOLD);
    check("idle_after_reset_halt", int'(pif.state), 0);

    // Randomized phase: per-cycle model comparison does the checking.
    hold_rst = 0;
    for (int n = 0; n < 8000; n++) begin
      @(negedge clk);
      if (hold_rst > 0) begin
        hold_rst--;
        if (hold_rst == 0) rst = 1'b0;
      end
      if ($urandom_range(0, 39) == 0) pif.nBUT_RUN   = ~pif.nBUT_RUN;
      if ($urandom_range(0, 59) == 0) pif.nBUT_CLEAR = ~pif.nBUT_CLEAR;
      if ($urandom_range(0, 29) == 0) pif.cpu_halted = ~pif.cpu_halted;
      if ($urandom_range(0, 49) == 0) pif.SW_STEP    = ~pif.SW_STEP;
      pif.cpu_instr_done = ($urandom_range(0, 15) == 0);
      if (hold_rst == 0 && $urandom_range(0, 1999) == 0) begin
        #2 rst = 1'b1;
        hold_rst = $urandom_range(1, 3);
      end
    end
    rst = 1'b0;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pdp8_panel_sequencer.md
Name: pdp8_panel_sequencer

Overview:
Front-panel run-control sequencer between the board buttons/switches and the PDP8 core's control inputs. It synchronizes and debounces the two active-low push buttons and turns presses into clean one-shot commands. A small FSM then drives the core through clear, run, single-step and halt. The block replaces the direct wiring of inverted raw buttons onto the core's RESET/CLEAR/RUN/HALT inputs in the board top level.

Parameters:
DEBOUNCE_TICKS, 16, consecutive TICK strobes a synchronized button level must hold before it is accepted (min 2).
CLEAR_CYCLES, 4, CLK cycles that cpu_reset/cpu_clear are held high per clear (min 1).
CNT_W, 8, width of the debounce and clear counters (must hold max(DEBOUNCE_TICKS, CLEAR_CYCLES)).

Ports:
CLK  in  1  system clock (the divided CPU clock); all state on posedge.
RESET  in  1  asynchronous, active-high reset.
TICK  in  1  one-CLK-cycle debounce strobe (refresh-rate enable, ~48.8 kHz).
nBUT_RUN  in  1  raw RUN/STOP button, active low, asynchronous.
nBUT_CLEAR  in  1  raw CLEAR button, active low, asynchronous.
SW_STEP  in  1  1 = single-step mode; sampled only on a RUN press.
cpu_halted  in  1  core reports it is in the halted state (level).
cpu_instr_done  in  1  one-cycle pulse at the end of each instruction.
cpu_reset  out  1  to core sw_RESET.
cpu_clear  out  1  to core sw_CLEAR.
cpu_run  out  1  to core sw_RUN (level).
cpu_halt_req  out  1  to core sw_HALT (level).
led_run  out  1  high in RUNNING, STEPPING or HALTING.
led_busy  out  1  high in CLEARING.
state  out  3  current FSM encoding (debug).

Behaviour:
- Reset (async, RESET=1): FSM=IDLE; synchronizers and stable levels = 1 (released); counters = 0. All outputs 0.
- Input path, per button:
  - 2-flop synchronizer.
  - Debounce counter increments on TICK while the synced level differs from the stable level. It clears whenever the two match, regardless of TICK.
  - On the TICK that brings the count to DEBOUNCE_TICKS, the stable level flips and the counter clears.
  - A press event is a one-cycle pulse in the cycle after stable goes 1->0. Releases generate no event.
- FSM states: IDLE=0, CLEARING=1, RUNNING=2, STEPPING=3, HALTING=4. Outputs are registered from the next state, so they change in the same cycle the state changes.
- Any state, clear press → CLEARING. Clear-counter loads 0; cpu_reset=cpu_clear=1; cpu_run=cpu_halt_req=0.
- CLEARING: stays exactly CLEAR_CYCLES cycles, then → IDLE. A clear press during CLEARING restarts the count. Run presses are ignored.
- IDLE, run press:
  - SW_STEP=1 → STEPPING.
  - SW_STEP=0 → RUNNING.
  - Either way cpu_run=1.
- RUNNING, cpu_run=1:
  - run press → HALTING (cpu_halt_req=1, cpu_run stays 1).
  - cpu_halted=1 (core executed HLT) → IDLE.
- STEPPING, cpu_run=1: cpu_instr_done → IDLE. Exactly one instruction completes; cpu_run falls in the cycle after the pulse.
- HALTING: cpu_halted=1 → IDLE; cpu_halt_req and cpu_run fall together. Run presses are ignored.
- Simultaneous clear and run press in one cycle: clear wins.
- A run press coinciding with cpu_halted in RUNNING: the halt is taken → IDLE, and the press is discarded.
- Button events are never queued; only the current-cycle pulse is evaluated.
- Illegal state encodings → IDLE.

Decomposition:
- Shared package pdp8_panel_pkg holds the state encoding constants (IDLE..HALTING, width 3) and default DEBOUNCE_TICKS/CLEAR_CYCLES.
- One sub-module, pdp8_debounce: synchronizer, debounce counter and press-pulse generator. It is instantiated twice and parameterized by DEBOUNCE_TICKS/CNT_W.

Test Plan:
- Debounce: DEBOUNCE_TICKS=4, TICK every 8 CLK. nBUT_RUN bounces 0/1/0 over 2 ticks, then holds 0 → exactly one press pulse, 2 CLK after the 4th qualifying TICK. No pulse from the bounces or from the release.
- Clear: from RUNNING, press CLEAR, CLEAR_CYCLES=4 → cpu_reset=cpu_clear=1 for exactly 4 cycles and cpu_run=0 throughout, then state=0 and all outputs 0.
- Run/stop: IDLE, SW_STEP=0, RUN press → cpu_run=1, state=2. Second RUN press → cpu_halt_req=1, state=4. Assert cpu_halted → next cycle cpu_run=cpu_halt_req=0, state=0.
- Single step: SW_STEP=1, RUN press → state=3, cpu_run=1. Pulse cpu_instr_done after 10 cycles → cpu_run=0 next cycle. Three presses yield exactly three cpu_run windows.
- Priority: force both press pulses in the same cycle from IDLE → state=1, cpu_run never asserts.
- Async reset: assert RESET mid-CLEARING and mid-HALTING, between clock edges → all outputs 0 immediately, state=0. After release, only fresh debounced presses produce actions.
